// File: rtl/des_pkg.sv
// Shared DES constants: the standard bit-permutation/expansion tables (1-based,
// entry 1 first) and helpers for sizing permutation tables.
package des_pkg;

    typedef logic [1:32][5:0] des_p_tbl_t;

    localparam des_p_tbl_t DES_P = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

    localparam logic [1:64][6:0] DES_IP = {
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [1:64][6:0] DES_FP = {
        7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    // E expands 32 bits to 48, so it is not a bijection and only suits forward use.
    localparam logic [1:48][5:0] DES_E = {
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,
        6'd6,  6'd7,  6'd8,  6'd9,  6'd8,  6'd9,  6'd10, 6'd11,
        6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd24, 6'd25, 6'd26, 6'd27,
        6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    function automatic int idx_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_perm_core.sv
// Combinational table-driven bit mapper: forward gathers out[i] = in[T[i]],
// inverse scatters in[i] into out[T[i]] with OR on collisions.
module bit_perm_core
    import des_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic [WIDTH*IDX_W-1:0] tbl_i,
    input  logic [1:WIDTH]         data_i,
    input  logic                   inv_i,
    output logic [1:WIDTH]         data_o
);

    logic [1:WIDTH] fwd;
    logic [1:WIDTH] bwd;

    // Out-of-range entries match no index, so they contribute nothing either way.
    always_comb begin
        fwd = '0;
        bwd = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            for (int j = 1; j <= WIDTH; j++) begin
                if (tbl_i[(WIDTH-i)*IDX_W +: IDX_W] == IDX_W'(j)) begin
                    fwd[i] = fwd[i] | data_i[j];
                    bwd[j] = bwd[j] | data_i[i];
                end
            end
        end
    end

    assign data_o = inv_i ? bwd : fwd;

endmodule

// File: rtl/des_perm_engine.sv
// Pipelined runtime-programmable bit-permutation engine with a valid/ready
// stage chain and a registered table-bijection checker.
module des_perm_engine
    import des_pkg::*;
#(
    parameter int                     WIDTH      = 32,
    parameter int                     IDX_W      = 6,
    parameter int                     STAGES     = 1,
    parameter logic [WIDTH*IDX_W-1:0] PERM_TABLE = DES_P
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:WIDTH]   in_data,
    input  logic             in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:WIDTH]   out_data,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [IDX_W-1:0] cfg_data,
    output logic             tbl_err
);

    logic [WIDTH*IDX_W-1:0] tbl_q;
    logic [WIDTH*IDX_W-1:0] tbl_d;
    logic                   tbl_err_q;
    logic [STAGES-1:0]      valid_q;
    logic [STAGES-1:0]      load;
    logic [1:WIDTH]         data_q [STAGES];
    logic [1:WIDTH]         perm;

    // WIDTH entries cover 1..WIDTH exactly once iff every index is hit.
    function automatic logic not_bijection(input logic [WIDTH*IDX_W-1:0] t);
        logic err;
        logic hit;
        err = 1'b0;
        for (int j = 1; j <= WIDTH; j++) begin
            hit = 1'b0;
            for (int i = 1; i <= WIDTH; i++) begin
                if (t[(WIDTH-i)*IDX_W +: IDX_W] == IDX_W'(j)) begin
                    hit = 1'b1;
                end
            end
            if (!hit) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

    always_comb begin
        tbl_d = tbl_q;
        for (int j = 1; j <= WIDTH; j++) begin
            if (cfg_we && cfg_addr == IDX_W'(j)) begin
                tbl_d[(WIDTH-j)*IDX_W +: IDX_W] = cfg_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q     <= PERM_TABLE;
            tbl_err_q <= not_bijection(PERM_TABLE);
        end else begin
            tbl_q     <= tbl_d;
            tbl_err_q <= not_bijection(tbl_q);
        end
    end

    // The beat sees tbl_q, so a write landing on the same edge only affects later beats.
    bit_perm_core #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_core (
        .tbl_i  (tbl_q),
        .data_i (in_data),
        .inv_i  (in_inv),
        .data_o (perm)
    );

    always_comb begin
        load = '0;
        load[STAGES-1] = !valid_q[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = !valid_q[k] || load[k+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= perm;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign tbl_err   = tbl_err_q;

endmodule

// File: tb/tb_des_perm_engine.sv
// Scoreboard bench for des_perm_engine: accepted beats push model results,
// a negedge monitor pops and compares every emitted beat and the tbl_err flag.
module tb_des_perm_engine;
    import des_pkg::*;

    localparam int WIDTH  = 32;
    localparam int IDX_W  = 6;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:WIDTH]   in_data = '0;
    logic             in_inv = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [1:WIDTH]   out_data;
    logic             cfg_we = 1'b0;
    logic [IDX_W-1:0] cfg_addr = '0;
    logic [IDX_W-1:0] cfg_data = '0;
    logic             tbl_err;

    always #5 clk = ~clk;

    des_perm_engine #(
        .WIDTH      (WIDTH),
        .IDX_W      (IDX_W),
        .STAGES     (STAGES),
        .PERM_TABLE (DES_P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .tbl_err   (tbl_err)
    );

    int nChecks = 0;
    int nFails  = 0;

    int defTbl [1:WIDTH] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                             2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    int             mtbl [1:WIDTH];
    logic           merr = 1'b0;
    logic [1:WIDTH] expQ [$];
    logic           stalled = 1'b0;
    logic [1:WIDTH] stallData = '0;
    logic           randReady = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference permutation straight from the table definition.
    function automatic logic [1:WIDTH] modelPerm(input logic [1:WIDTH] x, input logic inv);
        logic [1:WIDTH] r;
        r = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            if (mtbl[i] >= 1 && mtbl[i] <= WIDTH) begin
                if (!inv) r[i] = x[mtbl[i]];
                else      r[mtbl[i]] = r[mtbl[i]] | x[i];
            end
        end
        return r;
    endfunction

    function automatic logic modelErr();
        int cnt [1:WIDTH];
        for (int j = 1; j <= WIDTH; j++) cnt[j] = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            if (mtbl[i] < 1 || mtbl[i] > WIDTH) return 1'b1;
            cnt[mtbl[i]]++;
        end
        for (int j = 1; j <= WIDTH; j++) begin
            if (cnt[j] != 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Monitor: compare emitted beats and tbl_err, then record what the next edge does.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("tbl_err", tbl_err, merr);
            if (stalled) begin
                checkOutput("stall_valid", out_valid, 1);
                checkOutput("stall_data", out_data, stallData);
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("[TB] FAIL unexpected_beat: actual=%0h required=none", out_data);
                end else begin
                    checkOutput("out_data", out_data, expQ.pop_front());
                end
            end
            stalled   = out_valid && !out_ready;
            stallData = out_data;
            if (in_valid && in_ready) expQ.push_back(modelPerm(in_data, in_inv));
            merr = modelErr();
            if (cfg_we && cfg_addr >= 1 && cfg_addr <= WIDTH) mtbl[cfg_addr] = int'(cfg_data);
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Offer one beat from a posedge+1 phase; returns at posedge+1 after acceptance.
    task automatic applyStimulus(input logic [1:WIDTH] d, input logic inv);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL accept_timeout: actual=no_accept required=accept");
        end
    endtask

    task automatic cfgWrite(input int addr, input int val);
        cfg_we   = 1'b1;
        cfg_addr = IDX_W'(addr);
        cfg_data = IDX_W'(val);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Direct latency check for a single beat into an empty, unstalled pipeline.
    task automatic expectOut(input string name, input logic [1:WIDTH] value);
        repeat (STAGES - 1) begin
            @(negedge clk);
            checkOutput({name, "_early"}, out_valid, 0);
        end
        @(negedge clk);
        checkOutput({name, "_valid"}, out_valid, 1);
        checkOutput(name, out_data, value);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        randReady = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && expQ.size() != 0; c++) @(posedge clk);
        #1;
        checkOutput("drain_empty", expQ.size(), 0);
    endtask

    task automatic modelReset();
        expQ.delete();
        stalled = 1'b0;
        mtbl    = defTbl;
        merr    = 1'b0;
    endtask

    initial begin
        logic [1:WIDTH] x;
        logic [1:WIDTH] a;
        logic [1:WIDTH] b;
        logic [1:WIDTH] c;

        modelReset();
        #2;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_tbl_err", tbl_err, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(32'h8000_0000, 1'b0);
        expectOut("fwd_p_msb", 32'h0080_0000);
        applyStimulus(32'h0000_0001, 1'b0);
        expectOut("fwd_p_lsb", 32'h0000_0800);
        applyStimulus(32'h0080_0000, 1'b1);
        expectOut("inv_p", 32'h8000_0000);

        // Backpressure: two stages fill, third beat must wait.
        a = $urandom; b = $urandom; c = $urandom;
        out_ready = 1'b0;
        applyStimulus(a, 1'b0);
        applyStimulus(b, 1'b1);
        in_data = c; in_inv = 1'b0; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("full_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("full_pass_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Duplicate entry sets the error one cycle after the table changes.
        cfgWrite(2, 16);
        @(negedge clk);
        @(negedge clk);
        checkOutput("dup_tbl_err", tbl_err, 1);
        @(posedge clk);
        #1;
        cfgWrite(2, 7);
        @(negedge clk);
        @(negedge clk);
        checkOutput("restore_tbl_err", tbl_err, 0);
        @(posedge clk);
        #1;

        randReady = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            x = $urandom;
            applyStimulus(x, 1'b0);
            applyStimulus(modelPerm(x, 1'b0), 1'b1);
        end
        drain();

        // Identity table; the beat sharing the last write still sees T[32]=25.
        for (int i = 1; i < WIDTH; i++) cfgWrite(i, i);
        cfg_we = 1'b1; cfg_addr = IDX_W'(WIDTH); cfg_data = IDX_W'(WIDTH);
        in_data = 32'h0000_0080; in_inv = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("same_cycle_ready", in_ready, 1);
        @(posedge clk);
        #1;
        cfg_we = 1'b0; in_valid = 1'b0;
        expectOut("old_entry_beat", 32'h0000_0081);
        checkOutput("identity_tbl_err", tbl_err, 0);
        applyStimulus(32'hDEAD_BEEF, 1'b0);
        expectOut("identity_deadbeef", 32'hDEAD_BEEF);
        applyStimulus(32'h0000_0080, 1'b0);
        expectOut("identity_new_entry", 32'h0000_0080);

        // Arbitrary (usually non-bijective) table; out-of-range addresses ignored.
        for (int i = 1; i <= WIDTH; i++) cfgWrite(i, $urandom_range(0, 63));
        cfgWrite(0, 5);
        cfgWrite(40, 3);
        randReady = 1'b1;
        for (int k = 0; k < 300; k++) applyStimulus($urandom, 1'($urandom_range(0, 1)));
        drain();

        // Reset with two beats stalled in flight.
        out_ready = 1'b0;
        applyStimulus($urandom, 1'b0);
        applyStimulus($urandom, 1'b1);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_out_data", out_data, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_tbl_err", tbl_err, 0);
        checkOutput("post_reset_idle", out_valid, 0);
        @(posedge clk);
        #1;
        applyStimulus(32'h8000_0000, 1'b0);
        expectOut("post_reset_p", 32'h0080_0000);
        drain();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
